// File: rtl/holy_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes,
// ALU operation codes and the operand/result multiplexer selects.
package holy_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBeq,
    StJal
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  // FSM-to-decoder request: fixed add, fixed sub, or decode from funct fields.
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResMemData   = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OpLoad) || (op == OpStore) || (op == OpRType) ||
           (op == OpIType) || (op == OpBranch) || (op == OpJal);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle.
//   ctrl modport: control unit (drives strobes/selects, reads instruction fields,
//                 ALU zero flag and memory ready).
//   dp modport:   datapath side (the reverse directions).
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic [2:0] alu_control;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [1:0] result_src;
  logic       illegal_instr;

  modport ctrl (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, adr_src, ir_write, pc_write, reg_write, mem_write,
           alu_control, alu_src_a, alu_src_b, imm_src, result_src, illegal_instr
  );

  modport dp (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, adr_src, ir_write, pc_write, reg_write, mem_write,
           alu_control, alu_src_a, alu_src_b, imm_src, result_src, illegal_instr
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder.
//   funct3, funct7b5 : instruction function fields
//   op5              : opcode bit 5 (1 = R-type, enables sub via funct7b5)
//   alu_op           : FSM request (add / sub / funct-decoded)
//   alu_control      : ALU operation select
module alu_decoder
  import holy_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = AluAdd;
    unique case (alu_op)
      AluOpAdd: alu_control = AluAdd;
      AluOpSub: alu_control = AluSub;
      default: begin
        unique case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? AluSub : AluAdd;
          3'b010:  alu_control = AluSlt;
          3'b110:  alu_control = AluOr;
          3'b111:  alu_control = AluAnd;
          // Unsupported funct3 quietly executes as add.
          default: alu_control = AluAdd;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Sequential control unit for the multi-cycle core. Walks each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath
// strobes and mux selects as Moore outputs of the state register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (forces FETCH)
//   bus   : ctrl modport of multicycle_control_if
module multicycle_control
  import holy_ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  multicycle_control_if.ctrl bus
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIType:         state_d = StExecuteI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = bus.op[5] ? StMemWrite : StMemRead;
      StMemRead:  if (bus.mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (bus.mem_ready) state_d = StFetch;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    bus.mem_req       = 1'b0;
    bus.adr_src       = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.mem_write     = 1'b0;
    bus.illegal_instr = 1'b0;
    bus.alu_src_a     = SrcAPc;
    bus.alu_src_b     = SrcBRs2;
    bus.imm_src       = ImmI;
    bus.result_src    = ResAluOut;
    alu_op            = AluOpAdd;
    unique case (state_q)
      StFetch: begin
        bus.mem_req    = 1'b1;
        bus.alu_src_b  = SrcBFour;
        bus.result_src = ResAluResult;
        // PC+4 and IR load commit only on the cycle the fetch completes.
        bus.ir_write   = bus.mem_ready;
        bus.pc_write   = bus.mem_ready;
      end
      StDecode: begin
        // Branch/jump target precomputed here and parked in the ALU output reg.
        bus.alu_src_a     = SrcAOldPc;
        bus.alu_src_b     = SrcBImm;
        bus.imm_src       = (bus.op == OpJal) ? ImmJ : ImmB;
        bus.illegal_instr = !is_legal_op(bus.op);
      end
      StMemAdr: begin
        bus.alu_src_a = SrcARs1;
        bus.alu_src_b = SrcBImm;
        bus.imm_src   = bus.op[5] ? ImmS : ImmI;
      end
      StMemRead: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
      end
      StMemWrite: begin
        bus.mem_req   = 1'b1;
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
      end
      StMemWb: begin
        bus.result_src = ResMemData;
        bus.reg_write  = 1'b1;
      end
      StExecuteR: begin
        bus.alu_src_a = SrcARs1;
        bus.alu_src_b = SrcBRs2;
        alu_op        = AluOpFunct;
      end
      StExecuteI: begin
        bus.alu_src_a = SrcARs1;
        bus.alu_src_b = SrcBImm;
        bus.imm_src   = ImmI;
        alu_op        = AluOpFunct;
      end
      StAluWb: begin
        bus.result_src = ResAluOut;
        bus.reg_write  = 1'b1;
      end
      StBeq: begin
        bus.alu_src_a  = SrcARs1;
        bus.alu_src_b  = SrcBRs2;
        alu_op         = AluOpSub;
        bus.result_src = ResAluOut;
        bus.pc_write   = bus.zero;
      end
      StJal: begin
        // Link value old PC + 4 is computed while the target loads the PC.
        bus.alu_src_a  = SrcAOldPc;
        bus.alu_src_b  = SrcBFour;
        bus.result_src = ResAluOut;
        bus.pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_op      (alu_op),
    .alu_control (bus.alu_control)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: reset/abort sequences,
// a table of per-instruction summaries, and random instructions checked
// cycle by cycle against a per-instruction expected trace.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal;
    logic [2:0] alu;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [1:0] res;
  } outs_t;

  typedef struct packed {
    logic  mr;
    outs_t v;
    outs_t m;
  } cyc_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         fw;
    int         mw;
    int         cycles;
    int         alu;
    int         regw;
    int         memw;
    int         pcw;
    int         ill;
  } vec_t;

  cyc_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic outs_t get_outs();
    outs_t o;
    o.mem_req   = bus.mem_req;
    o.adr_src   = bus.adr_src;
    o.ir_write  = bus.ir_write;
    o.pc_write  = bus.pc_write;
    o.reg_write = bus.reg_write;
    o.mem_write = bus.mem_write;
    o.illegal   = bus.illegal_instr;
    o.alu       = bus.alu_control;
    o.sa        = bus.alu_src_a;
    o.sb        = bus.alu_src_b;
    o.imm       = bus.imm_src;
    o.res       = bus.result_src;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.zero     = z;
  endtask

  // ALU operation an instruction should request, straight from the ISA rules.
  function automatic int spec_alu(input bit is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 1 : 0;
      3'b010:  return 5;
      3'b110:  return 3;
      3'b111:  return 2;
      default: return 0;
    endcase
  endfunction

  // One expected cycle. Strobes are always checked; a negative select means "don't care".
  task automatic ex(input logic mr, input int req, input int adr, input int irw, input int pcw,
                    input int rw, input int mw, input int ill, input int alu, input int sa,
                    input int sb, input int imm, input int res);
    cyc_t c;
    c.mr = mr;
    c.v  = '0;
    c.m  = '0;
    c.v.mem_req   = req[0]; c.m.mem_req   = 1'b1;
    c.v.ir_write  = irw[0]; c.m.ir_write  = 1'b1;
    c.v.pc_write  = pcw[0]; c.m.pc_write  = 1'b1;
    c.v.reg_write = rw[0];  c.m.reg_write = 1'b1;
    c.v.mem_write = mw[0];  c.m.mem_write = 1'b1;
    c.v.illegal   = ill[0]; c.m.illegal   = 1'b1;
    if (adr >= 0) begin c.v.adr_src = adr[0];  c.m.adr_src = 1'b1;  end
    if (alu >= 0) begin c.v.alu     = alu[2:0]; c.m.alu     = 3'b111; end
    if (sa >= 0)  begin c.v.sa      = sa[1:0];  c.m.sa      = 2'b11;  end
    if (sb >= 0)  begin c.v.sb      = sb[1:0];  c.m.sb      = 2'b11;  end
    if (imm >= 0) begin c.v.imm     = imm[1:0]; c.m.imm     = 2'b11;  end
    if (res >= 0) begin c.v.res     = res[1:0]; c.m.res     = 2'b11;  end
    exp_q.push_back(c);
  endtask

  // Expected trace of one instruction.
  // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal.
  task automatic model_instr(input int kind, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw);
    int st;
    st = (kind == 1) ? 1 : 0;
    for (int w = 0; w < fw; w++) ex(1'b0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, -1, 2);
    ex(1'b1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 2, -1, 2);
    ex(rb(), 0, -1, 0, 0, 0, 0, (kind == 6) ? 1 : 0, 0, 1, 1,
       (kind == 4) ? 2 : (kind == 5) ? 3 : -1, -1);
    case (kind)
      0, 1: begin
        ex(rb(), 0, -1, 0, 0, 0, 0, 0, 0, 2, 1, st, -1);
        for (int w = 0; w < mw; w++) ex(1'b0, 1, 1, 0, 0, 0, st, 0, -1, -1, -1, -1, -1);
        ex(1'b1, 1, 1, 0, 0, 0, st, 0, -1, -1, -1, -1, -1);
        if (kind == 0) ex(rb(), 0, -1, 0, 0, 1, 0, 0, -1, -1, -1, -1, 1);
      end
      2, 3: begin
        ex(rb(), 0, -1, 0, 0, 0, 0, 0, spec_alu(kind == 2, f3, f7), 2,
           (kind == 2) ? 0 : 1, (kind == 2) ? -1 : 0, -1);
        ex(rb(), 0, -1, 0, 0, 1, 0, 0, -1, -1, -1, -1, 0);
      end
      4: ex(rb(), 0, -1, 0, z ? 1 : 0, 0, 0, 0, 1, 2, 0, -1, 0);
      5: begin
        ex(rb(), 0, -1, 0, 1, 0, 0, 0, 0, 1, 2, -1, 0);
        ex(rb(), 0, -1, 0, 0, 1, 0, 0, -1, -1, -1, -1, 0);
      end
      default: ;
    endcase
  endtask

  // Table entry: reactive memory, tallies strobes, measures length.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc, regw, memw, pcw, ill, alu, fcnt, mcnt;
    bit in_fetch, left, done;
    cyc = 0; regw = 0; memw = 0; pcw = 0; ill = 0; alu = -1; fcnt = 0; mcnt = 0;
    left = 0; done = 0;
    set_instr(v.op, v.f3, v.f7, v.z);
    while (!done && cyc < 40) begin
      in_fetch = bus.mem_req && !bus.adr_src;
      if (in_fetch && left) begin
        done = 1;
      end else begin
        if (in_fetch) begin
          bus.mem_ready = (fcnt >= v.fw);
          fcnt++;
        end else begin
          left = 1;
          if (bus.mem_req) begin
            bus.mem_ready = (mcnt >= v.mw);
            mcnt++;
          end else begin
            bus.mem_ready = rb();
          end
        end
        @(negedge clk);
        regw += int'(bus.reg_write);
        memw += int'(bus.mem_write);
        pcw  += int'(bus.pc_write);
        ill  += int'(bus.illegal_instr);
        if (cyc == v.fw + 2) alu = int'(bus.alu_control);
        cyc++;
        @(posedge clk);
        #1;
      end
    end
    check($sformatf("v%0d finished", idx), int'(done), 1);
    check($sformatf("v%0d cycles", idx), cyc, v.cycles);
    if (v.alu >= 0) check($sformatf("v%0d alu_control", idx), alu, v.alu);
    check($sformatf("v%0d reg_write count", idx), regw, v.regw);
    check($sformatf("v%0d mem_write count", idx), memw, v.memw);
    check($sformatf("v%0d pc_write count", idx), pcw, v.pcw);
    check($sformatf("v%0d illegal count", idx), ill, v.ill);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tab[15];
    logic [6:0] op;
    int kind, fw, mw;
    logic [2:0] f3;
    logic f7, z;
    outs_t o;

    //          op          f3      f7    z    fw mw cyc alu rw mw pcw ill
    tab[0]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 4, 1, 1, 0, 1, 0};
    tab[1]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4, 0, 1, 0, 1, 0};
    tab[2]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 4, 0, 1, 0, 1, 0};
    tab[3]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0, 4, 5, 1, 0, 1, 0};
    tab[4]  = '{7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 4, 3, 1, 0, 1, 0};
    tab[5]  = '{7'b0110011, 3'b111, 1'b1, 1'b0, 0, 0, 4, 2, 1, 0, 1, 0};
    tab[6]  = '{7'b0010011, 3'b001, 1'b0, 1'b0, 0, 0, 4, 0, 1, 0, 1, 0};
    tab[7]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 5, 0, 1, 0, 1, 0};
    tab[8]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2, 7, 0, 1, 0, 1, 0};
    tab[9]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 0, 1, 5, 0, 0, 2, 1, 0};
    tab[10] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 3, 1, 0, 0, 2, 0};
    tab[11] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 3, 1, 0, 0, 1, 0};
    tab[12] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 4, 0, 1, 0, 2, 0};
    tab[13] = '{7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0, 2, -1, 0, 0, 1, 1};
    tab[14] = '{7'b0110011, 3'b000, 1'b1, 1'b0, 2, 0, 6, 1, 1, 0, 1, 0};

    // Reset held with memory not ready: stays in FETCH, no commits.
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst%0d mem_req", i), int'(bus.mem_req), 1);
      check($sformatf("rst%0d ir_write", i), int'(bus.ir_write), 0);
      check($sformatf("rst%0d pc_write", i), int'(bus.pc_write), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post-reset adr_src", int'(bus.adr_src), 0);
    check("post-reset alu_src_b", int'(bus.alu_src_b), 2);
    check("post-reset ir_write", int'(bus.ir_write), 0);
    @(posedge clk);
    #1 bus.mem_ready = 1'b1;
    @(negedge clk);
    check("fetch ir_write", int'(bus.ir_write), 1);
    check("fetch pc_write", int'(bus.pc_write), 1);
    @(posedge clk);
    #1;
    check("decode ir_write", int'(bus.ir_write), 0);
    check("decode mem_req", int'(bus.mem_req), 0);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // Reset during MEMWRITE aborts the store immediately.
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("memwrite mem_write", int'(bus.mem_write), 1);
    check("memwrite adr_src", int'(bus.adr_src), 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort mem_write", int'(bus.mem_write), 0);
    check("abort adr_src", int'(bus.adr_src), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("release mem_req", int'(bus.mem_req), 1);
    check("release alu_src_b", int'(bus.alu_src_b), 2);
    check("release mem_write", int'(bus.mem_write), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) run_vec(tab[i], i);

    // Random instructions against the expected per-cycle trace.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 6);
      f3   = 3'($urandom_range(0, 7));
      f7   = rb();
      z    = rb();
      fw   = $urandom_range(0, 2);
      mw   = $urandom_range(0, 2);
      case (kind)
        0: op = 7'b0000011;
        1: op = 7'b0100011;
        2: op = 7'b0110011;
        3: op = 7'b0010011;
        4: op = 7'b1100011;
        5: op = 7'b1101111;
        default: begin
          op = 7'b0000011;
          while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                 op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111)
            op = 7'($urandom_range(0, 127));
        end
      endcase
      set_instr(op, f3, f7, z);
      exp_q.delete();
      model_instr(kind, f3, f7, z, fw, mw);
      for (int c = 0; c < exp_q.size(); c++) begin
        bus.mem_ready = exp_q[c].mr;
        @(negedge clk);
        o = get_outs();
        total++;
        if (((o ^ exp_q[c].v) & exp_q[c].m) != '0) begin
          bad++;
          $display("FAIL rnd%0d op=%b cyc%0d: got %h expected %h (mask %h)", n, op, c,
                   o & exp_q[c].m, exp_q[c].v, exp_q[c].m);
        end
        @(posedge clk);
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
